multi_cycle_ctrl: RTL and testbench

MULTI_CYCLE_CTRL -- requirements
Module: multi_cycle_ctrl

---
 rtl/multi_cycle_ctrl.sv | 131 +++++++++++++
 tb/tb_multi_cycle_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle processor control FSM: sequences IF/ID/EX/MEM/WB and produces the
// datapath enables for each stage, plus a free-running retired-instruction counter.
module multi_cycle_ctrl (
  input  logic        clk,
  input  logic        resetn,
  input  logic        step_mode,
  input  logic        step,
  input  logic        inst_jbr,
  input  logic        inst_store,
  input  logic        inst_load,
  input  logic        inst_wb,
  input  logic        inst_mul,
  input  logic        mul_done,
  output logic [4:0]  stage,
  output logic        ir_wen,
  output logic        pc_wen,
  output logic        mul_start,
  output logic        rf_wen,
  output logic [3:0]  dm_wen,
  output logic        retire,
  output logic [31:0] retire_cnt
);

  // Encodings are the one-hot stage vector, so stage comes straight off the state register.
  typedef enum logic [4:0] {
    StIf  = 5'b00001,
    StId  = 5'b00010,
    StEx  = 5'b00100,
    StMem = 5'b01000,
    StWb  = 5'b10000
  } state_e;

  state_e      state_q, state_d;
  logic        mul_busy_q, mul_busy_d;
  logic        ex_done;
  logic [31:0] retire_cnt_q;

  always_comb begin
    state_d    = state_q;
    mul_busy_d = 1'b0;
    ex_done    = 1'b0;
    ir_wen     = 1'b0;
    pc_wen     = 1'b0;
    mul_start  = 1'b0;
    rf_wen     = 1'b0;
    dm_wen     = 4'h0;
    retire     = 1'b0;

    unique case (state_q)
      StIf: begin
        if (!step_mode || step) begin
          ir_wen  = 1'b1;
          state_d = StId;
        end
      end
      StId: begin
        if (inst_jbr) begin
          pc_wen  = 1'b1;
          retire  = 1'b1;
          state_d = StIf;
        end else begin
          state_d = StEx;
        end
      end
      StEx: begin
        ex_done = 1'b1;
        if (inst_mul) begin
          // mul_busy_q is clear only on the first EX cycle, so a done there is ignored.
          mul_start  = !mul_busy_q;
          ex_done    = mul_busy_q && mul_done;
          mul_busy_d = !ex_done;
        end
        if (ex_done) begin
          if (inst_store || inst_load) begin
            state_d = StMem;
          end else if (inst_wb) begin
            state_d = StWb;
          end else begin
            pc_wen  = 1'b1;
            retire  = 1'b1;
            state_d = StIf;
          end
        end
      end
      StMem: begin
        if (inst_store) begin
          dm_wen  = 4'hF;
          pc_wen  = 1'b1;
          retire  = 1'b1;
          state_d = StIf;
        end else begin
          state_d = StWb;
        end
      end
      StWb: begin
        rf_wen  = 1'b1;
        pc_wen  = 1'b1;
        retire  = 1'b1;
        state_d = StIf;
      end
      default: state_d = StIf;
    endcase

    if (!resetn) begin
      ir_wen    = 1'b0;
      pc_wen    = 1'b0;
      mul_start = 1'b0;
      rf_wen    = 1'b0;
      dm_wen    = 4'h0;
      retire    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= StIf;
      mul_busy_q   <= 1'b0;
      retire_cnt_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      mul_busy_q <= mul_busy_d;
      if (retire) begin
        retire_cnt_q <= retire_cnt_q + 32'd1;
      end
    end
  end

  assign stage      = state_q;
  assign retire_cnt = retire_cnt_q;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Scoreboard bench for multi_cycle_ctrl: per-cycle expected outputs are queued as
// each instruction is generated, then popped and compared while driving the DUT.
module tb_multi_cycle_ctrl;

  localparam logic [4:0] SIf  = 5'b00001;
  localparam logic [4:0] SId  = 5'b00010;
  localparam logic [4:0] SEx  = 5'b00100;
  localparam logic [4:0] SMem = 5'b01000;
  localparam logic [4:0] SWb  = 5'b10000;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        step_mode = 1'b0;
  logic        step = 1'b0;
  logic        inst_jbr = 1'b0;
  logic        inst_store = 1'b0;
  logic        inst_load = 1'b0;
  logic        inst_wb = 1'b0;
  logic        inst_mul = 1'b0;
  logic        mul_done = 1'b0;
  logic [4:0]  stage;
  logic        ir_wen;
  logic        pc_wen;
  logic        mul_start;
  logic        rf_wen;
  logic [3:0]  dm_wen;
  logic        retire;
  logic [31:0] retire_cnt;

  multi_cycle_ctrl dut (
    .clk        (clk),
    .resetn     (resetn),
    .step_mode  (step_mode),
    .step       (step),
    .inst_jbr   (inst_jbr),
    .inst_store (inst_store),
    .inst_load  (inst_load),
    .inst_wb    (inst_wb),
    .inst_mul   (inst_mul),
    .mul_done   (mul_done),
    .stage      (stage),
    .ir_wen     (ir_wen),
    .pc_wen     (pc_wen),
    .mul_start  (mul_start),
    .rf_wen     (rf_wen),
    .dm_wen     (dm_wen),
    .retire     (retire),
    .retire_cnt (retire_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, smode, stp, md, jbr, st, ld, wb, mul;
    logic [4:0] stg;
    logic       ir, pc, ms, rf, ret;
    logic [3:0] dm;
  } cyc_t;

  cyc_t        sb_q[$];
  int          n_chk = 0;
  int          n_pass = 0;
  int          cyc_no = 0;
  logic [31:0] exp_cnt = 32'd0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s @cycle %0d: got %h expected %h", tag, cyc_no, got, exp);
    end
  endtask

  function automatic void push(logic rst, logic smode, logic stp, logic md, logic jbr, logic st,
                               logic ld, logic wb, logic mul, logic [4:0] stg, logic ir,
                               logic pc, logic ms, logic rf, logic [3:0] dm, logic ret);
    cyc_t c;
    c.rst = rst; c.smode = smode; c.stp = stp; c.md = md;
    c.jbr = jbr; c.st = st; c.ld = ld; c.wb = wb; c.mul = mul;
    c.stg = stg; c.ir = ir; c.pc = pc; c.ms = ms; c.rf = rf; c.dm = dm; c.ret = ret;
    sb_q.push_back(c);
  endfunction

  // Reference sequencing for one instruction. Outside IF, step_mode/step are randomised
  // since they must have no effect once the instruction has left IF.
  function automatic void gen_instr(logic jbr, logic st, logic ld, logic wb, logic mul,
                                    int n_ex, logic smode, logic early);
    int  n;
    logic last, fin;
    push(0, smode, smode, early & mul, jbr, st, ld, wb, mul, SIf, 1, 0, 0, 0, 4'h0, 0);
    push(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), early & mul,
         jbr, st, ld, wb, mul, SId, 0, jbr, 0, 0, 4'h0, jbr);
    if (jbr) return;
    n = mul ? n_ex : 1;
    for (int i = 0; i < n; i++) begin
      last = (i == n - 1);
      fin  = last && !(st || ld) && !wb;
      push(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           mul && (last || (early && i == 0)), jbr, st, ld, wb, mul,
           SEx, 0, fin, mul && (i == 0), 0, 4'h0, fin);
    end
    if (st || ld) begin
      push(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, jbr, st, ld, wb, mul,
           SMem, 0, st, 0, 0, st ? 4'hF : 4'h0, st);
      if (st) return;
    end
    if (ld || wb) begin
      push(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, jbr, st, ld, wb, mul,
           SWb, 0, 1, 0, 1, 4'h0, 1);
    end
  endfunction

  function automatic void gen_idle(int n);
    for (int i = 0; i < n; i++) push(0, 1, 0, 0, 0, 0, 0, 0, 0, SIf, 0, 0, 0, 0, 4'h0, 0);
  endfunction

  task automatic run_sb();
    cyc_t c;
    while (sb_q.size() != 0) begin
      c = sb_q.pop_front();
      @(negedge clk);
      resetn     = !c.rst;
      step_mode  = c.smode;
      step       = c.stp;
      mul_done   = c.md;
      inst_jbr   = c.jbr;
      inst_store = c.st;
      inst_load  = c.ld;
      inst_wb    = c.wb;
      inst_mul   = c.mul;
      #1;
      chk("stage", 32'(stage), 32'(c.stg));
      chk("ir_wen", 32'(ir_wen), 32'(c.ir));
      chk("pc_wen", 32'(pc_wen), 32'(c.pc));
      chk("mul_start", 32'(mul_start), 32'(c.ms));
      chk("rf_wen", 32'(rf_wen), 32'(c.rf));
      chk("dm_wen", 32'(dm_wen), 32'(c.dm));
      chk("retire", 32'(retire), 32'(c.ret));
      chk("retire_cnt", retire_cnt, exp_cnt);
      if (c.rst) exp_cnt = 32'd0;
      else if (c.ret) exp_cnt = exp_cnt + 32'd1;
      cyc_no++;
    end
  endtask

  initial begin
    @(posedge clk);
    // Reset with step_mode=0: ir_wen must still be held low.
    push(1, 0, 0, 0, 0, 0, 0, 0, 0, SIf, 0, 0, 0, 0, 4'h0, 0);
    push(1, 0, 0, 0, 0, 0, 0, 0, 0, SIf, 0, 0, 0, 0, 4'h0, 0);
    gen_instr(0, 0, 0, 1, 0, 1, 0, 0);   // ALU write-back, 4 cycles
    gen_instr(0, 0, 1, 1, 0, 1, 0, 0);   // LW, 5 cycles
    gen_instr(0, 1, 0, 0, 0, 1, 0, 0);   // SW, 4 cycles
    gen_instr(1, 0, 0, 1, 0, 1, 0, 0);   // BEQ with inst_wb also set
    gen_instr(0, 0, 0, 0, 0, 1, 0, 0);   // non-writing, 3 cycles
    gen_instr(0, 1, 1, 1, 0, 1, 0, 0);   // store wins over load and wb
    gen_instr(0, 0, 1, 0, 0, 1, 0, 0);   // load without wb still writes back
    gen_instr(0, 0, 0, 1, 1, 6, 0, 0);   // mul: 6 EX cycles then WB
    gen_instr(0, 0, 0, 0, 1, 3, 0, 1);   // mul, done in start cycle ignored
    gen_instr(0, 0, 1, 1, 1, 2, 0, 0);   // mul feeding a load
    gen_idle(10);                        // step mode, no step
    gen_instr(0, 0, 0, 1, 0, 1, 1, 0);   // one stepped instruction
    gen_idle(3);
    // Reset during a mul stall.
    push(0, 0, 0, 0, 0, 0, 0, 1, 1, SIf, 1, 0, 0, 0, 4'h0, 0);
    push(0, 0, 0, 0, 0, 0, 0, 1, 1, SId, 0, 0, 0, 0, 4'h0, 0);
    push(0, 0, 0, 0, 0, 0, 0, 1, 1, SEx, 0, 0, 1, 0, 4'h0, 0);
    push(0, 0, 0, 0, 0, 0, 0, 1, 1, SEx, 0, 0, 0, 0, 4'h0, 0);
    push(1, 0, 0, 1, 0, 0, 0, 1, 1, SEx, 0, 0, 0, 0, 4'h0, 0);
    gen_instr(0, 0, 0, 1, 1, 3, 0, 1);   // late mul_done held high must be ignored
    gen_idle(2);
    run_sb();

    // Counter wrap: preload near the top, then retire two branches.
    @(negedge clk);
    force dut.retire_cnt_q = 32'hFFFF_FFFE;
    exp_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.retire_cnt_q;
    gen_instr(1, 0, 0, 0, 0, 1, 0, 0);
    gen_instr(1, 0, 0, 0, 0, 1, 0, 0);
    gen_idle(1);
    run_sb();
    chk("wrap", retire_cnt, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
